alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter CNT_W, default 16: width of each per-requester grant counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  2  bit i: requester i presents an operation.
REQ-006 req_ready  output  2  bit i: operation of requester i accepted this cycle.
REQ-007 req0_op, req1_op  input  3 each  opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 cmp.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  16 each  operands.
REQ-009 rsp_valid  output  1  result register holds an undelivered result.
REQ-010 rsp_ready  input  1  consumer takes the result this cycle.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  17  registered ALU result.
REQ-013 clr_cnt  input  1  synchronous clear of both grant counters.
REQ-014 gnt_cnt0, gnt_cnt1  output  CNT_W each  accepted-operation counts per requester.

Function
REQ-015 The block SHALL share a single combinational 16-bit ALU between the two requesters; only the granted requester's op/a/b SHALL drive it.
REQ-016 ALU results SHALL be 17 bits: add = a+b with carry in bit 16; sub = a-b modulo 2^17 (bit 16 = borrow); and/or/xor zero-extended; shl = a<<b truncated to 17 bits; shr = a>>b; shift amounts >=17 give 0.
REQ-017 cmp SHALL be unsigned: 0 if a==b, 1 if a>b, 2 if a<b.
REQ-018 Accept condition: free = !rsp_valid || rsp_ready; no grant SHALL be issued when free is 0.
REQ-019 With free=1 and exactly one req_valid bit set, that requester SHALL be granted.
REQ-020 With free=1 and both bits set, the requester selected by the priority pointer SHALL be granted.
REQ-021 After any grant the priority pointer SHALL point to the non-granted requester; without a grant it SHALL hold.
REQ-022 req_ready SHALL be combinational, one-hot or zero, set only for the granted requester.
REQ-023 On a grant at edge N, rsp_valid, rsp_id and rsp_data SHALL reflect that operation from edge N onward (one-cycle latency).
REQ-024 While rsp_valid=1 and rsp_ready=0, rsp_id and rsp_data SHALL hold stable.
REQ-025 rsp_valid=1, rsp_ready=1 with a new grant in the same cycle SHALL replace the result at the edge (back-to-back, 1 op/cycle).
REQ-026 rsp_valid=1, rsp_ready=1 with no grant SHALL clear rsp_valid at the edge; rsp_data and rsp_id SHALL hold.
REQ-027 Each grant SHALL increment the granted requester's counter by 1, wrapping from 2^CNT_W-1 to 0.
REQ-028 clr_cnt=1 SHALL zero both counters at the edge and take precedence over a simultaneous increment.
REQ-029 Requesters SHALL hold op/a/b stable while valid and not ready; the block SHALL NOT check this.

Reset
REQ-030 rst=1 SHALL immediately force rsp_valid=0, rsp_id=0, rsp_data=0, pointer=requester 0, gnt_cnt0=gnt_cnt1=0.
REQ-031 Reset during a pending result SHALL discard it; no grant SHALL occur while rst=1.
REQ-032 After rst deasserts, the first simultaneous request SHALL be granted to requester 0.

Verification
REQ-033 Req0 add 0xFFFF+0x0001, rsp_ready=1 -> req_ready=01, next cycle rsp_valid=1, rsp_id=0, rsp_data=0x10000.
REQ-034 Both valid after reset, req0 sub 3-5, req1 cmp 7 vs 9, rsp_ready=1 -> grants 0 then 1; rsp_data 0x1FFFE then 0x00002.
REQ-035 Result pending, rsp_ready=0 for 3 cycles with both valid -> req_ready=00, rsp_data stable; on rsp_ready=1 next grant goes to pointer requester.
REQ-036 Req1 shl 0x8001<<1 then shr 0x8000>>20 -> rsp_data 0x10002 then 0x00000; gnt_cnt1=2.
REQ-037 CNT_W=2, 4 grants to req0 with clr_cnt pulsed on the 5th grant cycle -> gnt_cnt0 0,1,2,3,0 then 0.
REQ-038 rst asserted mid-stream with rsp_valid=1 -> rsp_valid=0 at once, counters 0, first post-reset contested grant to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter sharing one 17-bit-result ALU
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req0_op,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic [2:0]       req1_op,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [16:0]      rsp_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Priority pointer: requester that wins the next contested cycle.
    logic        ptr;
    logic        free;
    logic        grant;
    logic        sel;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        big_shift;
    logic [16:0] alu_y;

    // Arbitration: grant only when the result register can take a new value and not in reset.
    always_comb begin
        free  = !rsp_valid || rsp_ready;
        grant = 1'b0;
        sel   = ptr;
        if (!rst && free) begin
            case (req_valid)
                2'b01:   begin grant = 1'b1; sel = 1'b0; end
                2'b10:   begin grant = 1'b1; sel = 1'b1; end
                2'b11:   begin grant = 1'b1; sel = ptr;  end
                default: begin grant = 1'b0; sel = ptr;  end
            endcase
        end
        req_ready = 2'b00;
        if (grant) begin
            req_ready = sel ? 2'b10 : 2'b01;
        end
    end

    // Operand steering: only the selected requester drives the shared ALU.
    always_comb begin
        if (sel) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end else begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end
    end

    // Shared ALU; shift amounts of 17 or more flush the result to zero.
    always_comb begin
        big_shift = (|alu_b[15:5]) || (alu_b[4:0] >= 5'd17);
        case (alu_op)
            OP_ADD:  alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_y = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_y = {1'b0, alu_a & alu_b};
            OP_OR:   alu_y = {1'b0, alu_a | alu_b};
            OP_XOR:  alu_y = {1'b0, alu_a ^ alu_b};
            OP_SHL:  alu_y = big_shift ? 17'd0 : ({1'b0, alu_a} << alu_b[4:0]);
            OP_SHR:  alu_y = big_shift ? 17'd0 : {1'b0, alu_a >> alu_b[4:0]};
            OP_CMP: begin
                if (alu_a == alu_b) begin
                    alu_y = 17'd0;
                end else if (alu_a > alu_b) begin
                    alu_y = 17'd1;
                end else begin
                    alu_y = 17'd2;
                end
            end
            default: alu_y = 17'd0;
        endcase
    end

    // Result register: load on grant, drop valid when consumed without a replacement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 17'd0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= sel;
            rsp_data  <= alu_y;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Pointer moves to the loser after every grant, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant) begin
            ptr <= ~sel;
        end
    end

    // Grant counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (clr_cnt) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (grant) begin
            if (sel) begin
                gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
            end else begin
                gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and random checks of alu_arbiter against a reference model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [2:0]  req0_op = 3'd0;
    logic [15:0] req0_a = 16'd0;
    logic [15:0] req0_b = 16'd0;
    logic [2:0]  req1_op = 3'd0;
    logic [15:0] req1_a = 16'd0;
    logic [15:0] req1_b = 16'd0;
    logic        rsp_ready = 1'b0;
    logic        clr_cnt = 1'b0;

    logic [1:0]  req_ready, req_ready_s;
    logic        rsp_valid, rsp_valid_s;
    logic        rsp_id, rsp_id_s;
    logic [16:0] rsp_data, rsp_data_s;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic [1:0]  gnt_cnt0_s, gnt_cnt1_s;

    int passed = 0;
    int total  = 0;

    // Reference model state
    bit          m_valid;
    int unsigned m_id, m_data, m_ptr, m_cnt0, m_cnt1;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .clr_cnt(clr_cnt), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    alu_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_id(rsp_id_s), .rsp_data(rsp_data_s),
        .clr_cnt(clr_cnt), .gnt_cnt0(gnt_cnt0_s), .gnt_cnt1(gnt_cnt1_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int unsigned ref_alu(input int unsigned op, input int unsigned a, input int unsigned b);
        int unsigned r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= 17) ? 0 : (a << b);
            6: r = (b >= 17) ? 0 : (a >> b);
            default: r = (a == b) ? 0 : ((a > b) ? 1 : 2);
        endcase
        return r & 32'h1FFFF;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_id = 0; m_data = 0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
        chk({tag, ":rsp_id"}, 32'(rsp_id), m_id);
        chk({tag, ":rsp_data"}, 32'(rsp_data), m_data);
        chk({tag, ":gnt_cnt0"}, 32'(gnt_cnt0), m_cnt0 & 32'hFFFF);
        chk({tag, ":gnt_cnt1"}, 32'(gnt_cnt1), m_cnt1 & 32'hFFFF);
        chk({tag, ":small_data"}, 32'(rsp_data_s), m_data);
        chk({tag, ":small_cnt0"}, 32'(gnt_cnt0_s), m_cnt0 & 32'h3);
        chk({tag, ":small_cnt1"}, 32'(gnt_cnt1_s), m_cnt1 & 32'h3);
    endtask

    // One clock cycle: check combinational grant mid-cycle, advance model at the edge, check after.
    task automatic step(input string tag);
        int          g;
        int unsigned y;
        logic [31:0] exp_rdy;
        @(negedge clk);
        g = -1;
        y = 0;
        if (!rst && (!m_valid || rsp_ready)) begin
            if (req_valid == 2'b01) g = 0;
            else if (req_valid == 2'b10) g = 1;
            else if (req_valid == 2'b11) g = int'(m_ptr);
        end
        exp_rdy = (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2);
        chk({tag, ":req_ready"}, 32'(req_ready), exp_rdy);
        chk({tag, ":small_req_ready"}, 32'(req_ready_s), exp_rdy);
        if (g == 0) y = ref_alu(req0_op, req0_a, req0_b);
        else if (g == 1) y = ref_alu(req1_op, req1_a, req1_b);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_valid = 1'b1; m_id = g; m_data = y; m_ptr = 1 - g;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            if (clr_cnt) begin
                m_cnt0 = 0; m_cnt1 = 0;
            end else if (g == 0) begin
                m_cnt0++;
            end else if (g == 1) begin
                m_cnt1++;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic [1:0] v, input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic rr, input logic cc);
        req_valid = v;
        req0_op = o0; req0_a = a0; req0_b = b0;
        req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready = rr; clr_cnt = cc;
    endtask

    // Asynchronous reset applied mid-cycle, held for two edges, released away from an edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ":async"});
        step({tag, ":hold0"});
        step({tag, ":hold1"});
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset("init");

        // Add with carry out
        drive(2'b01, 3'd0, 16'hFFFF, 16'h0001, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        step("add_carry");
        chk("add_carry:lit_data", 32'(rsp_data), 32'h10000);
        chk("add_carry:lit_id", 32'(rsp_id), 32'd0);
        drive(2'b00, 3'd0, 16'd0, 16'd0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        step("drain");
        chk("drain:lit_data_hold", 32'(rsp_data), 32'h10000);

        // Contested requests right after reset: requester 0 first, then 1
        do_reset("r34");
        drive(2'b11, 3'd1, 16'd3, 16'd5, 3'd7, 16'd7, 16'd9, 1'b1, 1'b0);
        step("contest0");
        chk("contest0:lit_data", 32'(rsp_data), 32'h1FFFE);
        step("contest1");
        chk("contest1:lit_data", 32'(rsp_data), 32'h00002);
        chk("contest1:lit_id", 32'(rsp_id), 32'd1);

        // Back-pressure holds the result and blocks grants
        drive(2'b01, 3'd0, 16'd1, 16'd2, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        step("bp_load");
        drive(2'b11, 3'd2, 16'hF0F0, 16'h0FF0, 3'd4, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("bp_stall");
        chk("bp_stall:lit_data", 32'(rsp_data), 32'd3);
        rsp_ready = 1'b1;
        step("bp_release");
        chk("bp_release:lit_id", 32'(rsp_id), 32'd1);

        // Shift boundaries on requester 1
        do_reset("r36");
        drive(2'b10, 3'd0, 16'd0, 16'd0, 3'd5, 16'h8001, 16'd1, 1'b1, 1'b0);
        step("shl");
        chk("shl:lit_data", 32'(rsp_data), 32'h10002);
        drive(2'b10, 3'd0, 16'd0, 16'd0, 3'd6, 16'h8000, 16'd20, 1'b1, 1'b0);
        step("shr_big");
        chk("shr_big:lit_data", 32'(rsp_data), 32'h0);
        chk("shr_big:lit_cnt1", 32'(gnt_cnt1), 32'd2);
        drive(2'b10, 3'd0, 16'd0, 16'd0, 3'd5, 16'h0001, 16'd16, 1'b1, 1'b0);
        step("shl16");
        drive(2'b10, 3'd0, 16'd0, 16'd0, 3'd5, 16'h0001, 16'd17, 1'b1, 1'b0);
        step("shl17");

        // Small counter wraps, then clear beats a simultaneous grant
        do_reset("r37");
        drive(2'b01, 3'd3, 16'h1234, 16'h4321, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("wrap");
        chk("wrap:lit_small_cnt0", 32'(gnt_cnt0_s), 32'd0);
        chk("wrap:lit_cnt0", 32'(gnt_cnt0), 32'd4);
        clr_cnt = 1'b1;
        step("clr_on_grant");
        chk("clr_on_grant:lit_cnt0", 32'(gnt_cnt0), 32'd0);
        clr_cnt = 1'b0;

        // Reset while a result is pending
        drive(2'b01, 3'd4, 16'h00FF, 16'h0F0F, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        step("pend");
        req_valid = 2'b11;
        do_reset("r38");
        chk("r38:lit_valid", 32'(rsp_valid), 32'd0);
        drive(2'b11, 3'd0, 16'd10, 16'd20, 3'd1, 16'd30, 16'd5, 1'b1, 1'b0);
        step("post_rst");
        chk("post_rst:lit_id", 32'(rsp_id), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom),
                  3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand_rst");
            end else begin
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
